// File: rtl/fletcher_pkg.sv
// Shared definitions for the Fletcher checksum generator and verifier:
// modulus helper, frame state encoding and checksum wire order.
package fletcher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    CK_LO,
    CK_HI,
    RESULT
  } state_e;

  // The low half (a) travels first, matching the generator's {b,a} output.
  localparam bit CkLowFirst = 1'b1;

  function automatic longint unsigned fletcher_mod(input int unsigned widthHalf);
    return (64'd1 << widthHalf) - 64'd1;
  endfunction

endpackage

// File: rtl/fletcher_modadd.sv
// Combinational modular add (x + y) mod (2^WidthHalf - 1); operands never
// exceed the modulus, so a single conditional subtraction is sufficient.
module fletcher_modadd
  import fletcher_pkg::*;
#(
  parameter int WidthHalf = 16
) (
  input  logic [WidthHalf-1:0] x_i,
  input  logic [WidthHalf-1:0] y_i,
  output logic [WidthHalf-1:0] sum_o
);

  localparam logic [WidthHalf:0] Mod = (WidthHalf+1)'(fletcher_mod(WidthHalf));

  logic [WidthHalf:0] rawSum;

  always_comb begin
    rawSum = {1'b0, x_i} + {1'b0, y_i};
    if (rawSum >= Mod) begin
      sum_o = WidthHalf'(rawSum - Mod);
    end else begin
      sum_o = rawSum[WidthHalf-1:0];
    end
  end

endmodule

// File: rtl/fletcher_verifier.sv
// Receive-side Fletcher checksum verifier: recomputes {b,a} over a fixed-length
// payload and compares it to the trailing checksum. Optional error counter: FLETCHER_VERIFIER_ERRCNT_EN.
module fletcher_verifier
  import fletcher_pkg::*;
#(
  parameter int Width     = 32,
  parameter int WordCount = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 din_valid_i,
  input  logic [Width/2-1:0]   din_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ok_o,
  output logic [Width-1:0]     cksum_o,
  output logic [7:0]           errcnt_o
);

  localparam int WidthHalf = Width / 2;
  localparam int CntW      = $clog2(WordCount) + 1;
  localparam logic [CntW-1:0]      LastWord = CntW'(WordCount - 1);
  localparam logic [WidthHalf-1:0] AllOnes  = {WidthHalf{1'b1}};

  state_e               state_q;
  logic [WidthHalf-1:0] a_q, b_q, a_d, b_d;
  logic [WidthHalf-1:0] rxA_q, rxB_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q, done_q, ok_q;

  logic [WidthHalf-1:0] dinNorm, rxAFinal, rxBFinal;
  logic                 match;

  fletcher_modadd #(.WidthHalf(WidthHalf)) uAddA (
    .x_i  (a_q),
    .y_i  (din_i),
    .sum_o(a_d)
  );

  fletcher_modadd #(.WidthHalf(WidthHalf)) uAddB (
    .x_i  (b_q),
    .y_i  (a_d),
    .sum_o(b_d)
  );

  // All-ones is the second encoding of zero, so received halves are folded.
  always_comb begin
    dinNorm  = (din_i == AllOnes) ? '0 : din_i;
    rxAFinal = CkLowFirst ? rxA_q : dinNorm;
    rxBFinal = CkLowFirst ? dinNorm : rxB_q;
    match    = (rxAFinal == a_q) && (rxBFinal == b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rxA_q   <= '0;
      rxB_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else if (start_i) begin
      state_q <= PAYLOAD;
      a_q     <= '0;
      b_q     <= '0;
      rxA_q   <= '0;
      rxB_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        PAYLOAD: begin
          if (din_valid_i) begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastWord) state_q <= CK_LO;
          end
        end
        CK_LO: begin
          if (din_valid_i) begin
            if (CkLowFirst) rxA_q <= dinNorm;
            else            rxB_q <= dinNorm;
            state_q <= CK_HI;
          end
        end
        CK_HI: begin
          if (din_valid_i) begin
            rxA_q   <= rxAFinal;
            rxB_q   <= rxBFinal;
            ok_q    <= match;
            done_q  <= 1'b1;
            state_q <= RESULT;
          end
        end
        RESULT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FLETCHER_VERIFIER_ERRCNT_EN
  logic       frameBad;
  logic [7:0] errCnt_q;

  assign frameBad = (state_q == CK_HI) && din_valid_i && !start_i && !match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCnt_q <= '0;
    end else if (frameBad && (errCnt_q != 8'hFF)) begin
      errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign errcnt_o = errCnt_q;
`else
  assign errcnt_o = '0;
`endif

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign ok_o    = ok_q;
  assign cksum_o = {b_q, a_q};

endmodule
